// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tone_sequencer
//  Description : Queued note player; FIFO of note requests rendered back to
//                back as a PWM-gated square wave on the amplifier pins.
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_sequencer #(
    parameter int CLK_HZ      = 100000000,
    parameter int OCT_W       = 3,
    parameter int VOL_W       = 4,
    parameter int DUR_W       = 10,
    parameter int TICK_CYCLES = 100000,
    parameter int GAP_TICKS   = 10,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_note,
    input  logic [OCT_W-1:0] req_octave,
    input  logic [VOL_W-1:0] req_vol,
    input  logic [DUR_W-1:0] req_dur,
    input  logic             flush,
    output logic             AIN,
    output logic             GAIN,
    output logic             NC,
    output logic             ACTIVE,
    output logic             busy
);

    // Rest codes 12..15 reuse the C frequency; their speaker output stays silent.
    localparam int C_FREQ_HZ [16] = '{262, 277, 294, 311, 330, 349, 370, 392,
                                      415, 440, 466, 494, 262, 262, 262, 262};
    localparam int C_HALF_W = $clog2(CLK_HZ / (2 * 262) + 1);
    localparam int C_TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int C_GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int C_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int C_ENT_W  = 4 + OCT_W + VOL_W + DUR_W;

    localparam logic [C_TICK_W-1:0] C_TICK_LAST = C_TICK_W'(TICK_CYCLES - 1);
    localparam logic [C_GAP_W-1:0]  C_GAP_LAST  = C_GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [C_PTR_W:0]    C_DEPTH     = (C_PTR_W + 1)'(FIFO_DEPTH);

    function automatic logic [15:0][C_HALF_W-1:0] half_table();
        logic [15:0][C_HALF_W-1:0] tab;
        for (int i = 0; i < 16; i++) begin
            tab[i] = C_HALF_W'(CLK_HZ / (2 * C_FREQ_HZ[i]));
        end
        return tab;
    endfunction

    localparam logic [15:0][C_HALF_W-1:0] C_HALF_TAB = half_table();

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [C_ENT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [C_ENT_W-1:0]   mem_d [FIFO_DEPTH];
    logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [C_PTR_W:0]     count_q, count_d;
    logic [3:0]           note_q, note_d;
    logic [OCT_W-1:0]     oct_q, oct_d;
    logic [VOL_W-1:0]     vol_q, vol_d;
    logic [C_HALF_W-1:0]  half_q, half_d, half_cnt_q, half_cnt_d;
    logic [C_TICK_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [DUR_W-1:0]     dur_cnt_q, dur_cnt_d;
    logic [C_GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [VOL_W-1:0]     pwm_cnt_q, pwm_cnt_d;
    logic                 speaker_q, speaker_d, ain_q, ain_d;

    logic                 w_full, w_empty, w_push, w_pop, w_rest;
    logic [C_HALF_W-1:0]  w_half_shift, w_half_eff;

    assign w_full       = (count_q == C_DEPTH);
    assign w_empty      = (count_q == '0);
    assign req_ready    = !w_full && !flush;
    assign w_push       = req_valid && req_ready;
    assign w_pop        = (state_q == S_IDLE) && !w_empty && !flush;
    assign w_rest       = (note_q[3:2] == 2'b11);
    assign w_half_shift = C_HALF_TAB[note_q] >> oct_q;
    assign w_half_eff   = (w_half_shift == '0) ? C_HALF_W'(1) : w_half_shift;

    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        note_d     = note_q;
        oct_d      = oct_q;
        vol_d      = vol_q;
        half_d     = half_q;
        half_cnt_d = half_cnt_q;
        tick_cnt_d = tick_cnt_q;
        dur_cnt_d  = dur_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        speaker_d  = speaker_q;
        pwm_cnt_d  = pwm_cnt_q + 1'b1;
        ain_d      = speaker_q && (pwm_cnt_q < vol_q);

        if (w_push) begin
            mem_d[wr_ptr_q] = {req_note, req_octave, req_vol, req_dur};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (C_PTR_W + 1)'(w_push) - (C_PTR_W + 1)'(w_pop);

        case (state_q)
            S_IDLE: begin
                if (w_pop) begin
                    {note_d, oct_d, vol_d, dur_cnt_d} = mem_q[rd_ptr_q];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                half_d     = w_half_eff;
                half_cnt_d = w_half_eff - 1'b1;
                tick_cnt_d = C_TICK_LAST;
                speaker_d  = 1'b0;
                state_d    = (dur_cnt_q == '0) ? S_IDLE : S_PLAY;
            end
            S_PLAY: begin
                if (half_cnt_q == '0) begin
                    half_cnt_d = half_q - 1'b1;
                    speaker_d  = !w_rest && !speaker_q;
                end else begin
                    half_cnt_d = half_cnt_q - 1'b1;
                end
                if (tick_cnt_q == '0) begin
                    tick_cnt_d = C_TICK_LAST;
                    dur_cnt_d  = dur_cnt_q - 1'b1;
                    // Note end overrides a half-period toggle landing on the same cycle.
                    if (dur_cnt_q == DUR_W'(1)) begin
                        speaker_d = 1'b0;
                        gap_cnt_d = C_GAP_LAST;
                        state_d   = (GAP_TICKS > 0) ? S_GAP : S_IDLE;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (tick_cnt_q == '0) begin
                    tick_cnt_d = C_TICK_LAST;
                    if (gap_cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 1'b1;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flush silences AIN on the same edge rather than one cycle later.
        if (flush) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            state_d   = S_IDLE;
            speaker_d = 1'b0;
            ain_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            note_q     <= '0;
            oct_q      <= '0;
            vol_q      <= '0;
            half_q     <= '0;
            half_cnt_q <= '0;
            tick_cnt_q <= '0;
            dur_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            pwm_cnt_q  <= '0;
            speaker_q  <= 1'b0;
            ain_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            note_q     <= note_d;
            oct_q      <= oct_d;
            vol_q      <= vol_d;
            half_q     <= half_d;
            half_cnt_q <= half_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            dur_cnt_q  <= dur_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            speaker_q  <= speaker_d;
            ain_q      <= ain_d;
        end
    end

    assign busy   = (state_q != S_IDLE) || !w_empty;
    assign ACTIVE = busy;
    assign AIN    = ain_q;
    assign GAIN   = 1'b1;
    assign NC     = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tone_sequencer
//  Description : Directed self-checking bench for tone_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_sequencer;

    localparam int CLK_HZ      = 88000;
    localparam int OCT_W       = 3;
    localparam int VOL_W       = 4;
    localparam int DUR_W       = 10;
    localparam int TICK_CYCLES = 1000;
    localparam int GAP_TICKS   = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int T           = TICK_CYCLES;
    localparam int G           = GAP_TICKS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             flush = 1'b0;
    logic [3:0]       req_note = '0;
    logic [OCT_W-1:0] req_octave = '0;
    logic [VOL_W-1:0] req_vol = '0;
    logic [DUR_W-1:0] req_dur = '0;
    logic             req_ready, AIN, GAIN, NC, ACTIVE, busy;

    tone_sequencer #(
        .CLK_HZ(CLK_HZ), .OCT_W(OCT_W), .VOL_W(VOL_W), .DUR_W(DUR_W),
        .TICK_CYCLES(TICK_CYCLES), .GAP_TICKS(GAP_TICKS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_note(req_note), .req_octave(req_octave), .req_vol(req_vol),
        .req_dur(req_dur), .flush(flush), .AIN(AIN), .GAIN(GAIN), .NC(NC),
        .ACTIVE(ACTIVE), .busy(busy)
    );

    always #5 clk = ~clk;

    // Edges since reset release; the DUT PWM counter equals cyc mod 16.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge following the accepting edge.
    task automatic push(input int note, input int oct, input int vol, input int dur,
                        output int acc);
        bit got = 1'b0;
        acc        = -1;
        req_note   = 4'(note);
        req_octave = OCT_W'(oct);
        req_vol    = VOL_W'(vol);
        req_dur    = DUR_W'(dur);
        req_valid  = 1'b1;
        for (int t = 0; t < 20000 && !got; t++) begin
            if (req_ready) begin
                acc = cyc + 1;
                got = 1'b1;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (!got) check("push_timeout", 0, 1);
    endtask

    // n0 = edge after which the FIFO head is popped on the next edge.
    task automatic expect_note(input int n0, input int h, input int d, input int vol,
                               input int rest, input int last, input string tag);
        int k, m, j, spk, e_ain, e_busy, last_k;
        int bad_ain = 0;
        int bad_busy = 0;
        last_k = n0 + 2 + d * T + G * T;
        do begin
            @(negedge clk);
            k = cyc;
            if (k >= n0 + 1) begin
                m      = k - 1;
                j      = m - (n0 + 2);
                spk    = (rest == 0 && j >= 0 && j < d * T) ? (j / h) % 2 : 0;
                e_ain  = (spk == 1 && (m % 16) < vol) ? 1 : 0;
                e_busy = (k == last_k && last != 0) ? 0 : 1;
                if (AIN !== 1'(e_ain)) bad_ain++;
                if (busy !== 1'(e_busy) || ACTIVE !== 1'(e_busy)) bad_busy++;
            end
        end while (k < last_k);
        check({tag, "_ain_bad_cycles"}, bad_ain, 0);
        check({tag, "_busy_bad_cycles"}, bad_busy, 0);
    endtask

    int t3_note [6] = '{0, 4, 7, 11, 2, 9};
    int t3_oct  [6] = '{0, 0, 1, 0, 2, 0};
    int t3_vol  [6] = '{15, 9, 12, 4, 15, 8};
    int t3_half [6] = '{167, 133, 56, 89, 37, 100};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2, k;
        int acc [6];

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", req_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_ain", AIN, 0);
        check("reset_active", ACTIVE, 0);
        check("gain_const", GAIN, 1);
        check("nc_const", NC, 0);

        // 1: A4, three ticks, full volume
        push(9, 0, 15, 3, n);
        expect_note(n, 100, 3, 15, 0, 1, "t1_a_oct0");

        // 2: octave shift and clamp to a 1-cycle half period
        push(9, 1, 15, 1, n);
        expect_note(n, 50, 1, 15, 0, 1, "t2_a_oct1");
        push(9, 7, 15, 1, n);
        expect_note(n, 1, 1, 15, 0, 1, "t2_a_oct7");

        // 3: six back-to-back requests with valid held
        push(t3_note[0], t3_oct[0], t3_vol[0], 1, n);
        acc[0] = n;
        fork
            begin
                int a;
                for (int i = 1; i < 6; i++) begin
                    push(t3_note[i], t3_oct[i], t3_vol[i], 1, a);
                    acc[i] = a;
                    if (i == 4) check("t3_ready_when_full", req_ready, 0);
                end
                check("t3_r4_accept_edge", acc[4], acc[0] + 4);
                check("t3_r5_accept_edge", acc[5], acc[0] + 4 + T + G * T);
            end
            begin
                int nn;
                nn = acc[0];
                for (int i = 0; i < 6; i++) begin
                    expect_note(nn, t3_half[i], 1, t3_vol[i], 0, (i == 5) ? 1 : 0,
                                $sformatf("t3_note%0d", i));
                    nn = nn + 2 + T + G * T;
                end
            end
        join

        // 4: volume extremes
        push(9, 0, 0, 1, n);
        expect_note(n, 100, 1, 0, 0, 1, "t4_vol0");
        push(9, 0, 8, 1, n);
        expect_note(n, 100, 1, 8, 0, 1, "t4_vol8");

        // 5: flush during a speaker-high phase with a request offered
        push(9, 0, 15, 3, n);
        push(0, 0, 15, 1, n2);
        k = n + 2 + 100 + 2;
        if ((k - 1) % 16 == 15) k++;
        while (cyc < k - 1) @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_note  = 4'd4;
        #1;
        check("t5_ready_during_flush", req_ready, 0);
        @(negedge clk);
        check("t5_ain_after_flush", AIN, 0);
        check("t5_busy_after_flush", busy, 0);
        flush     = 1'b0;
        req_valid = 1'b0;
        #1;
        check("t5_ready_after_flush", req_ready, 1);
        push(11, 0, 15, 1, n);
        expect_note(n, 89, 1, 15, 0, 1, "t5_after_flush");

        // 6: async reset mid-note with an entry queued
        push(9, 0, 15, 3, n);
        push(4, 0, 15, 2, n2);
        while (cyc < n + 2 + 104) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_ain_in_reset", AIN, 0);
        check("t6_busy_in_reset", busy, 0);
        check("t6_active_in_reset", ACTIVE, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_ready_after_reset", req_ready, 1);
        check("t6_busy_after_reset", busy, 0);
        push(9, 0, 15, 0, n);
        push(12, 0, 15, 2, n2);
        check("t6_rest_accept_edge", n2, n + 1);
        expect_note(n + 2, 1, 2, 15, 1, 1, "t6_rest");
        push(9, 1, 8, 1, n);
        expect_note(n, 50, 1, 8, 0, 1, "t6_post_reset_note");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Parametrised successor to the fixed-scale demo tone generator.
- Accepts note requests (note, octave, volume, duration) through a valid/ready handshake into a small FIFO and plays them back-to-back as a square wave.
- Volume is a PWM gate; an optional silent gap separates consecutive notes.
- Drives the speaker amplifier pins AIN/GAIN/NC/ACTIVE directly; replaces the free-running scale player at the top level.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- OCT_W, 3, octave field width; octave k divides the half period by 2^k.
- VOL_W, 4, volume width; PWM resolution 2^VOL_W.
- DUR_W, 10, duration field width, in ticks.
- TICK_CYCLES, 100000, clock cycles per duration tick (1 ms at default).
- GAP_TICKS, 10, silent ticks inserted after each note; 0 = legato.
- FIFO_DEPTH, 4, request queue depth; power of two, ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid & ready
- req_note  in  4  semitone 0..11 (C..B); 12..15 = rest (silent, duration still honoured)
- req_octave  in  OCT_W  octave offset above base octave 4
- req_vol  in  VOL_W  PWM duty numerator
- req_dur  in  DUR_W  length in ticks
- flush  in  1  synchronous: empty FIFO, abort current note
- AIN  out  1  gated square wave to amplifier
- GAIN  out  1  constant 1
- NC  out  1  constant 0
- ACTIVE  out  1  amplifier enable, equals busy
- busy  out  1  high in LOAD/PLAY/GAP or when FIFO non-empty

Behaviour:
- Reset (async): FIFO empty, state IDLE, speaker 0, all counters 0. AIN=0, busy=0, ACTIVE=0, req_ready=1 once reset deasserts.
- Handshake:
  - req_ready = !full & !flush.
  - A push while full is impossible, even if a pop occurs the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO are both performed.
- Base half-period table, octave 0: half[n] = CLK_HZ / (2*f[n]), integer floor, computed at elaboration.
  - f = 262,277,294,311,330,349,370,392,415,440,466,494 Hz.
  - Effective half = half[n] >> octave; if the result is 0, use 1.
- FSM:
  - IDLE: if FIFO non-empty, pop the head into the working registers and go to LOAD.
  - LOAD (1 cycle): compute effective half and load half_cnt = half-1, tick_cnt = TICK_CYCLES-1, dur_cnt = dur. Speaker = 0. If dur = 0, go to IDLE (entry consumed, nothing played); else go to PLAY.
  - PLAY:
    - half_cnt counts down; at 0 toggle speaker and reload half-1, giving full period 2*half.
    - tick_cnt counts down; at 0 reload and decrement dur_cnt.
    - When dur_cnt reaches 0 on a tick: speaker forced 0; go to GAP if GAP_TICKS > 0, else IDLE.
    - Rest notes follow the same path with speaker held 0.
  - GAP: silent for GAP_TICKS*TICK_CYCLES cycles, then IDLE.
- PWM:
  - Free-running VOL_W-bit counter pwm_cnt, reset 0.
  - AIN = speaker & (pwm_cnt < vol), registered, so AIN lags speaker by 1 cycle.
  - vol = 0 gives AIN constant 0.
- Latency: a request accepted at edge N into an empty FIFO in IDLE is popped at N+1, enters LOAD at N+1, and is in PLAY from N+2. The first rising speaker edge comes half cycles after PLAY entry; AIN follows 1 cycle later.
- Flush: in the cycle it is sampled, the FIFO is cleared, the state goes to IDLE and speaker goes to 0. AIN is 0 from the next cycle. A req_valid in the same cycle is not accepted.
- Reset mid-note: immediate silence and all state cleared.
- Width rules:
  - dur_cnt is DUR_W bits.
  - tick_cnt is $clog2(TICK_CYCLES) bits.
  - half_cnt is sized for half[0] (C, largest).
  - No counter may wrap.

Test Plan (CLK_HZ=88000, TICK_CYCLES=1000, GAP_TICKS=2, VOL_W=4, FIFO_DEPTH=4):
1. Push A (note 9), oct 0, vol 15, dur 3 → speaker period 200 cycles (half=100). PLAY lasts 3000 cycles, then 2000 cycles of AIN=0, busy falls at IDLE. AIN high 15 of every 16 cycles during speaker-high phases.
2. Same note with oct 1 → half 50. Oct 7 → half 0 clamped to 1, speaker toggles every cycle.
3. Hold valid and push 6 back-to-back → the first 4 (one may pop) are accepted and ready drops while full. The notes play in order with a 2000-cycle gap between each, and no request is lost or duplicated.
4. vol 0 → AIN stays 0 for the whole note while busy stays 1. vol 8 → AIN duty 8/16 while speaker is high.
5. Assert flush mid-PLAY together with req_valid → the next cycle shows AIN=0, FIFO empty, IDLE, and the valid request is not accepted. After that the FIFO accepts again.
6. Pulse async rst mid-note and with dur=0 / rest=12 entries queued → reset clears everything immediately. The dur=0 entry is consumed with no output; the rest entry keeps AIN 0 for dur ticks plus the gap.
